// File: rtl/kronos_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kronos_lsu_pkg
//  Description : Shared types, error-cause codes and decode helpers for the
//                Kronos load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package kronos_lsu_pkg;

    // Access width as seen by the LSU; the reserved encoding folds into WORD.
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_size_e;

    // LSU control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // Exception cause codes reported on err_cause.
    localparam logic [1:0] C_ERR_LOAD_MISALIGN  = 2'd0;
    localparam logic [1:0] C_ERR_STORE_MISALIGN = 2'd1;
    localparam logic [1:0] C_ERR_LOAD_FAULT     = 2'd2;
    localparam logic [1:0] C_ERR_STORE_FAULT    = 2'd3;

    // One memory operation handed from EX to the LSU.
    typedef struct packed {
        logic        store;
        lsu_size_e   size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } pipeEXLSU_t;

    // Map the raw 2-bit size field onto the access width.
    function automatic lsu_size_e size_decode(input logic [1:0] raw);
        lsu_size_e s;
        case (raw)
            2'd0:    s = BYTE;
            2'd1:    s = HALF;
            default: s = WORD;
        endcase
        return s;
    endfunction

    // True when the low address bits do not match the access width.
    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
        logic m;
        case (size)
            HALF:    m = off[0];
            WORD:    m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage : kronos_lsu_pkg
`default_nettype wire

// File: rtl/kronos_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : kronos_lsu_align
//  Description : Combinational byte-lane logic: store mask and lane
//                replication, load lane extraction and sign/zero extension.
//                Low address bits that do not fit the access width are
//                ignored, which forces the access aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module kronos_lsu_align
    import kronos_lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  mask,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);

    logic [1:0]  w_off;
    logic [31:0] w_shifted;

    // Lane selection, store replication and load extension in one pass.
    always_comb begin
        w_off     = 2'b00;
        mask      = 4'b1111;
        st_lanes  = st_data;
        ld_data   = ld_raw;
        w_shifted = ld_raw;

        case (size)
            BYTE: begin
                w_off    = offset;
                mask     = 4'b0001 << offset;
                st_lanes = {4{st_data[7:0]}};
            end
            HALF: begin
                w_off    = {offset[1], 1'b0};
                mask     = offset[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
            end
            default: begin
                w_off    = 2'b00;
                mask     = 4'b1111;
                st_lanes = st_data;
            end
        endcase

        w_shifted = ld_raw >> {w_off, 3'b000};

        case (size)
            BYTE:    ld_data = is_unsigned ? {24'd0, w_shifted[7:0]}
                                           : {{24{w_shifted[7]}}, w_shifted[7:0]};
            HALF:    ld_data = is_unsigned ? {16'd0, w_shifted[15:0]}
                                           : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: ld_data = w_shifted;
        endcase
    end

endmodule : kronos_lsu_align
`default_nettype wire

// File: rtl/kronos_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : kronos_lsu
//  Description : Load/store unit. Accepts one op per handshake, issues one
//                word-aligned bus transaction with byte mask, writes back
//                extended load data and reports misalignment / bus-timeout
//                exceptions. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module kronos_lsu
    import kronos_lsu_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255,
    parameter int ALIGN_CHECK = 1
)(
    input  logic        clk,
    input  logic        rst,

    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,

    output logic [31:0] data_addr,
    output logic [31:0] data_wr_data,
    output logic [3:0]  data_mask,
    output logic        data_wr_en,
    output logic        data_req,
    input  logic [31:0] data_rd_data,
    input  logic        data_ack,

    output logic        regwr_en,
    output logic [4:0]  regwr_sel,
    output logic [31:0] regwr_data,

    output logic        done,
    output logic        err_vld,
    output logic [1:0]  err_cause,
    output logic [31:0] err_addr
);

    // The counter only ever holds 0 .. BUS_TIMEOUT-1.
    localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

    lsu_state_e  r_state;
    pipeEXLSU_t  r_op;
    logic [CW-1:0] r_cnt;

    pipeEXLSU_t  w_req;
    logic        w_in_idle;
    logic        w_misalign;
    logic        w_timeout;
    lsu_size_e   w_al_size;
    logic        w_al_unsigned;
    logic [1:0]  w_al_offset;
    logic [3:0]  w_mask;
    logic [31:0] w_st_lanes;
    logic [31:0] w_ld_data;

    // Bundle the incoming EX fields.
    always_comb begin
        w_req.store       = req_store;
        w_req.size        = size_decode(req_size);
        w_req.is_unsigned = req_unsigned;
        w_req.addr        = req_addr;
        w_req.wdata       = req_wdata;
        w_req.rd          = req_rd;
    end

    assign w_in_idle  = (r_state == IDLE);
    assign w_misalign = (ALIGN_CHECK != 0) && is_misaligned(w_req.size, w_req.addr[1:0]);

    // The lane logic serves the incoming op in IDLE (store mask/data) and
    // the held op afterwards (load extraction on ack).
    assign w_al_size     = w_in_idle ? w_req.size        : r_op.size;
    assign w_al_unsigned = w_in_idle ? w_req.is_unsigned : r_op.is_unsigned;
    assign w_al_offset   = w_in_idle ? w_req.addr[1:0]   : r_op.addr[1:0];

    kronos_lsu_align u_align (
        .size        (w_al_size),
        .is_unsigned (w_al_unsigned),
        .offset      (w_al_offset),
        .st_data     (w_req.wdata),
        .ld_raw      (data_rd_data),
        .mask        (w_mask),
        .st_lanes    (w_st_lanes),
        .ld_data     (w_ld_data)
    );

    // Watchdog expiry: the current BUS cycle is the last one allowed.
    generate
        if (BUS_TIMEOUT > 0) begin : g_wdog
            localparam logic [CW-1:0] C_CNT_LAST = CW'(BUS_TIMEOUT - 1);
            assign w_timeout = (r_cnt == C_CNT_LAST);
        end else begin : g_no_wdog
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Control FSM with registered bus, writeback and exception outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_op         <= '0;
            r_cnt        <= '0;
            req_rdy      <= 1'b1;
            data_addr    <= '0;
            data_wr_data <= '0;
            data_mask    <= '0;
            data_wr_en   <= 1'b0;
            data_req     <= 1'b0;
            regwr_en     <= 1'b0;
            regwr_sel    <= '0;
            regwr_data   <= '0;
            done         <= 1'b0;
            err_vld      <= 1'b0;
            err_cause    <= '0;
            err_addr     <= '0;
        end else begin
            done     <= 1'b0;
            err_vld  <= 1'b0;
            regwr_en <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (req_vld) begin
                        r_op    <= w_req;
                        req_rdy <= 1'b0;
                        r_cnt   <= '0;
                        if (w_misalign) begin
                            // Fault straight away; the bus is never touched.
                            r_state   <= RESP;
                            done      <= 1'b1;
                            err_vld   <= 1'b1;
                            err_cause <= req_store ? C_ERR_STORE_MISALIGN : C_ERR_LOAD_MISALIGN;
                            err_addr  <= req_addr;
                        end else begin
                            r_state      <= BUS;
                            data_req     <= 1'b1;
                            data_addr    <= {req_addr[31:2], 2'b00};
                            data_mask    <= w_mask;
                            data_wr_data <= w_st_lanes;
                            data_wr_en   <= req_store;
                        end
                    end
                end

                BUS: begin
                    if (data_ack) begin
                        // Ack wins over a coincident timeout.
                        r_state    <= RESP;
                        data_req   <= 1'b0;
                        data_wr_en <= 1'b0;
                        done       <= 1'b1;
                        if (!r_op.store) begin
                            regwr_sel  <= r_op.rd;
                            regwr_data <= w_ld_data;
                            regwr_en   <= (r_op.rd != 5'd0);
                        end
                    end else if (w_timeout) begin
                        r_state    <= RESP;
                        data_req   <= 1'b0;
                        data_wr_en <= 1'b0;
                        done       <= 1'b1;
                        err_vld    <= 1'b1;
                        err_cause  <= r_op.store ? C_ERR_STORE_FAULT : C_ERR_LOAD_FAULT;
                        err_addr   <= r_op.addr;
                    end else if (BUS_TIMEOUT > 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                RESP: begin
                    r_state <= IDLE;
                    req_rdy <= 1'b1;
                    r_cnt   <= '0;
                end

                default: begin
                    r_state <= IDLE;
                    req_rdy <= 1'b1;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule : kronos_lsu
`default_nettype wire

// File: doc/kronos_lsu.md
Name: kronos_lsu

Overview:
- Parametrised load/store unit that drives the core data interface, currently tied to zero in the core.
- Accepts one memory op per handshake from the EX stage and issues a single word-aligned bus transaction with byte mask.
- Returns sign/zero-extended load data as a register write, and reports misalignment and bus-timeout exceptions.
- Successor to the tied-off data path: adds size/mode handling, alignment checking and a configurable watchdog.

Parameters:
- BUS_TIMEOUT, 255: max cycles data_req may wait for data_ack before an access fault; 0 disables the watchdog.
- ALIGN_CHECK, 1: 1 = misaligned half/word ops fault without a bus access; 0 = low address bits are ignored (access forced aligned).

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_vld  in  1  EX presents a memory op
- req_rdy  out  1  LSU can accept (IDLE only)
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 = reserved, treated as word
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits significant)
- req_rd  in  5  load destination register
- data_addr  out  32  {addr[31:2], 2'b00}
- data_wr_data  out  32  lane-replicated store data
- data_mask  out  4  byte enables
- data_wr_en  out  1  store strobe qualifier
- data_req  out  1  bus request, held until ack/timeout
- data_rd_data  in  32  load data, valid with data_ack
- data_ack  in  1  bus completion
- regwr_en  out  1  one-cycle load writeback pulse
- regwr_sel  out  5  writeback register
- regwr_data  out  32  extended load data
- done  out  1  one-cycle completion pulse (every accepted op)
- err_vld  out  1  one-cycle exception pulse, coincident with done
- err_cause  out  2  0 = load misaligned, 1 = store misaligned, 2 = load access fault, 3 = store access fault
- err_addr  out  32  faulting byte address (req_addr as accepted)

Behaviour:
- Reset:
  - state = IDLE; req_rdy = 1.
  - data_req, data_wr_en, regwr_en, done and err_vld = 0.
  - data_addr, data_wr_data, data_mask, regwr_sel, regwr_data, err_cause, err_addr = 0.
  - Timeout counter = 0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_rdy = 1.
  - On req_vld, register addr, size, mode, rd and wdata.
  - If misaligned (half with addr[0] = 1, or word with addr[1:0] != 0) and ALIGN_CHECK = 1, go to RESP with a pending error; no bus access.
  - Otherwise go to BUS.
- BUS:
  - data_req = 1; data_addr, data_mask, data_wr_data and data_wr_en are stable for the whole state.
  - Counter increments each cycle without ack.
  - On data_ack, capture data_rd_data (loads) and go to RESP.
  - If the counter reaches BUS_TIMEOUT without ack (BUS_TIMEOUT != 0), drop data_req and go to RESP with an access fault.
  - Ack in the same cycle as timeout: ack wins, no fault.
- RESP:
  - Exactly one cycle; done = 1.
  - Load without error and rd != 0: regwr_en = 1. rd = 0 suppresses regwr_en but still raises done.
  - On error: err_vld = 1 and regwr_en = 0.
  - Returns to IDLE; counter cleared.
- Latency: accept at T, data_req at T+1, earliest ack at T+1, done at T+2, req_rdy again at T+3. Misaligned op: done/err_vld at T+1.
- Store mask and data:
  - Byte: mask = 1 << addr[1:0]; data = {4{wdata[7:0]}}.
  - Half: mask = 4'b0011 if addr[1] = 0, else 4'b1100; data = {2{wdata[15:0]}}.
  - Word: mask = 4'b1111; data = wdata.
- Loads: data_wr_en = 0, data_mask as for stores. Lane extracted = data_rd_data >> (8 * addr[1:0]), then sign or zero extended from 8/16 bits per req_unsigned; word passes through.
- A flush is not visible to the LSU. Once accepted, an op always completes; EX must not flush an accepted op.
- Reset mid-BUS: data_req drops immediately (asynchronous); no done pulse.

Decomposition:
- kronos_types additions:
  - lsu_size_e (BYTE/HALF/WORD).
  - Constants for err_cause codes.
  - pipeEXLSU_t struct bundling the req_* fields.
- Sub-module kronos_lsu_align (combinational): store mask/data lane replication and load extraction/extension. Reused by any future cached data path.

Test Plan:
- SB x5 = 0xA5 to addr 0x103, ack after 3 cycles -> data_addr 0x100, mask 4'b1000, wr_data 0xA5A5A5A5, data_req high exactly 3 cycles, done once, regwr_en 0.
- LB rd = 7 at 0x202, rd_data 0x1280_FF00 -> regwr_data 0xFFFF_FF80, regwr_sel 7; LBU same -> 0x0000_0080.
- LH at 0x301 with ALIGN_CHECK = 1 -> no data_req, done + err_vld at T+1, err_cause 0, err_addr 0x301.
- BUS_TIMEOUT = 4, store with no ack -> data_req high 4 cycles then low, err_cause 3. Repeat with ack on cycle 4 -> no fault.
- LW rd = 0 at 0x400, immediate ack -> done at T+2, regwr_en stays 0. Back-to-back req_vld -> second accepted at T+3.
- Assert rst while in BUS -> data_req low same cycle, all outputs at reset values, req_rdy = 1 after release.
